decode_stage: RTL
=================

Name: decode_stage

Overview:
- Registered RV32I instruction-decode pipeline stage between the fetch stage and the register-read/execute stage.
- Accepts a fetched instruction plus PC over a valid/ready handshake.
- Classifies the opcode, extracts register IDs and function fields, selects and sign-extends the correct immediate to XLEN, and flags illegal encodings.
- A 2-entry skid buffer (output register plus skid register) lets the downstream stall without a combinational ready path back to fetch.

Parameters:
- XLEN, 32, datapath width; sets out_imm and PC width. Legal values: 32 or 64.
- ALLOW_SYSTEM, 1, when 0 the SYSTEM opcode is reported illegal.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- flush  in  1  discard all held and incoming instructions
- in_valid  in  1  fetch holds an instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  passed-through PC
- out_op  out  10  one-hot class: ALUreg, ALUimm, Branch, JALR, JAL, AUIPC, LUI, Load, Store, SYSTEM
- out_rs1, out_rs2, out_rd  out  5 each  register IDs
- out_funct3  out  3 ; out_funct7  out  7
- out_imm  out  XLEN  selected, sign-extended immediate
- out_rd_we  out  1  instruction writes rd, and rd != 0
- out_uses_rs1, out_uses_rs2  out  1 each  operand usage
- out_illegal  out  1  illegal encoding
- out_muldiv  out  1  M-extension operation (see Optional Feature)

Behaviour:
- Reset (resetn low at a clk edge):
  - both valid flags 0, all data registers 0, so every out_* is 0.
  - in_ready is forced 0 while resetn is low.
  - Reset mid-transfer drops everything.
- Latency:
  - 1 cycle from the in_valid&&in_ready edge to out_valid, when the output register is empty or draining.
  - Full throughput, 1 instruction per cycle, with out_ready held high.
- Handshake:
  - A transfer occurs on a clk edge where valid&&ready.
  - in_ready = !skid_valid, taken straight from a register with no combinational path from out_ready.
  - Output registers are stable while out_valid && !out_ready.
- Skid rules:
  - If the output register is full, not draining, and an input is accepted: the decode goes to the skid register.
  - On the next output transfer, skid moves to the output register and skid_valid clears.
  - Order is always preserved.
- flush:
  - On an edge with flush=1, both valid flags clear, and any simultaneous input transfer is discarded.
  - The producer treats that input as consumed.
- Opcode class: instr[6:0] against the 10 RV32I opcodes.
- Illegal when any of:
  - instr[1:0] != 2'b11
  - no class matches
  - Branch with funct3 of 010 or 011
  - Load with funct3 of 011, 110 or 111
  - Store with funct3 > 010
  - JALR with funct3 != 000
  - ALUreg with funct7 not in {0000000, 0100000}, or with 0100000 on a funct3 other than 000/101
  - ALUimm shifts (funct3 001/101) with a bad funct7
  - SYSTEM when ALLOW_SYSTEM=0
- When illegal: out_op = 0, rd_we = 0, uses_* = 0; the bundle still flows.
- Immediate selection; every immediate is sign-extended from instr[31] to XLEN:
  - I-type for ALUimm, JALR, Load, SYSTEM
  - S-type for Store
  - B-type for Branch (bit 0 = 0)
  - U-type for LUI/AUIPC (low 12 bits = 0)
  - J-type for JAL
  - 0 for ALUreg and illegal
- rd_we: asserted for ALUreg, ALUimm, JAL, JALR, LUI, AUIPC, Load, SYSTEM, and only when rd != 0.
- uses_rs1: all classes except LUI, AUIPC, JAL.
- uses_rs2: ALUreg, Branch, Store.

Optional Feature:
- Macro: DECODE_RV32M_EN.
- Defined:
  - ALUreg with funct7 = 0000001 is legal; out_muldiv = 1; out_op = ALUreg.
- Undefined:
  - That encoding is illegal.
  - out_muldiv is tied to 0.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams
  - the op_class_e enum with its one-hot bit positions
  - the decoded-bundle packed struct decode_bundle_t, parametrised through XLEN-sized fields using a 64-bit max and truncation
- Combinational field/immediate/illegal logic lives in sub-module instr_decode_comb, which produces decode_bundle_t.
- decode_stage holds the skid buffer and the handshake only.

Test Plan:
- addi x1,x2,-1 (0xFFF10093), out_ready=1:
  - next cycle out_op=ALUimm, rs1=2, rd=1, imm=0xFFFFFFFF, rd_we=1, illegal=0.
- beq x0,x0,-4 (0xFE000EE3) then lui x5,0x12345 (0x123452B7), back-to-back:
  - imm=0xFFFFFFFC with uses_rs2=1, then imm=0x12345000 with uses_rs1=0.
- Three instructions sent with out_ready=0:
  - first held in the output register, second in skid.
  - in_ready=0 the cycle after the second is accepted.
  - Raise out_ready: outputs emerge in order on consecutive cycles and in_ready returns to 1.
- 0x00000000, and Load with funct3=111:
  - out_illegal=1, out_op=0, rd_we=0, imm=0.
- Both entries full, flush=1 together with in_valid=1:
  - out_valid=0 and in_ready=1 next cycle; no instruction emerges afterwards.
- mul x3,x1,x2 (0x022081B3):
  - with DECODE_RV32M_EN: muldiv=1, illegal=0.
  - without it: illegal=1.
  - Also resetn low mid-stall clears out_valid on the next edge.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared opcode constants, op-class bit positions and the decoded bundle for the
// RV32I decode stage.
package decode_pkg;

  localparam int XLEN_MAX = 64;
  localparam int OP_W     = 10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Values are the bit positions inside the one-hot out_op vector.
  typedef enum logic [3:0] {
    OP_ALUREG = 4'd0, OP_ALUIMM = 4'd1, OP_BRANCH = 4'd2, OP_JALR  = 4'd3,
    OP_JAL    = 4'd4, OP_AUIPC  = 4'd5, OP_LUI    = 4'd6, OP_LOAD  = 4'd7,
    OP_STORE  = 4'd8, OP_SYSTEM = 4'd9
  } op_class_e;

  // pc/imm are carried at the widest legal XLEN and truncated at the stage output.
  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [OP_W-1:0]     op;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [XLEN_MAX-1:0] imm;
    logic                rd_we;
    logic                uses_rs1;
    logic                uses_rs2;
    logic                illegal;
    logic                muldiv;
  } decode_bundle_t;

  function automatic logic [XLEN_MAX-1:0] sext12(input logic [11:0] v);
    return {{(XLEN_MAX-12){v[11]}}, v};
  endfunction

  function automatic logic [XLEN_MAX-1:0] sext32(input logic [31:0] v);
    return {{(XLEN_MAX-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [9:0]      out_op;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic            out_rd_we;
  logic            out_uses_rs1;
  logic            out_uses_rs2;
  logic            out_illegal;
  logic            out_muldiv;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_op, out_rs1, out_rs2, out_rd,
           out_funct3, out_funct7, out_imm, out_rd_we, out_uses_rs1,
           out_uses_rs2, out_illegal, out_muldiv
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_op, out_rs1, out_rs2, out_rd,
           out_funct3, out_funct7, out_imm, out_rd_we, out_uses_rs1,
           out_uses_rs2, out_illegal, out_muldiv
  );
endinterface

// File: rtl/decode_stage_comb.sv
// Combinational RV32I field extraction, immediate selection and legality check.
// DECODE_RV32M_EN makes funct7=0000001 on the register-ALU opcode legal (muldiv).
module instr_decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int ALLOW_SYSTEM = 1
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output decode_bundle_t  dec_o
);

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [OP_W-1:0] cls;
  logic            ill, md;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];

  always_comb begin
    cls = '0;
    ill = 1'b0;
    md  = 1'b0;
    case (opc)
      OPC_OP: begin
        cls[OP_ALUREG] = 1'b1;
        if (f7 == 7'b0100000) begin
          ill = !(f3 == 3'b000 || f3 == 3'b101);
        end else if (f7 == 7'b0000001) begin
`ifdef DECODE_RV32M_EN
          md = 1'b1;
`else
          ill = 1'b1;
`endif
        end else if (f7 != 7'b0000000) begin
          ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        cls[OP_ALUIMM] = 1'b1;
        if (f3 == 3'b001)      ill = (f7 != 7'b0000000);
        else if (f3 == 3'b101) ill = !(f7 == 7'b0000000 || f7 == 7'b0100000);
      end
      OPC_BRANCH: begin
        cls[OP_BRANCH] = 1'b1;
        ill = (f3 == 3'b010 || f3 == 3'b011);
      end
      OPC_JALR: begin
        cls[OP_JALR] = 1'b1;
        ill = (f3 != 3'b000);
      end
      OPC_JAL:   cls[OP_JAL]   = 1'b1;
      OPC_AUIPC: cls[OP_AUIPC] = 1'b1;
      OPC_LUI:   cls[OP_LUI]   = 1'b1;
      OPC_LOAD: begin
        cls[OP_LOAD] = 1'b1;
        ill = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      end
      OPC_STORE: begin
        cls[OP_STORE] = 1'b1;
        ill = (f3 > 3'b010);
      end
      OPC_SYSTEM: begin
        cls[OP_SYSTEM] = 1'b1;
        ill = (ALLOW_SYSTEM == 0);
      end
      default: ill = 1'b1;
    endcase
    if (instr_i[1:0] != 2'b11) ill = 1'b1;
  end

  always_comb begin
    dec_o          = '0;
    dec_o.pc       = 64'(pc_i);
    dec_o.rs1      = instr_i[19:15];
    dec_o.rs2      = instr_i[24:20];
    dec_o.rd       = instr_i[11:7];
    dec_o.funct3   = f3;
    dec_o.funct7   = f7;
    dec_o.illegal  = ill;
    if (!ill) begin
      dec_o.op     = cls;
      dec_o.muldiv = md;
      if (cls[OP_ALUIMM] || cls[OP_JALR] || cls[OP_LOAD] || cls[OP_SYSTEM])
        dec_o.imm = sext12(instr_i[31:20]);
      else if (cls[OP_STORE])
        dec_o.imm = sext12({instr_i[31:25], instr_i[11:7]});
      else if (cls[OP_BRANCH])
        dec_o.imm = sext32({{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0});
      else if (cls[OP_LUI] || cls[OP_AUIPC])
        dec_o.imm = sext32({instr_i[31:12], 12'b0});
      else if (cls[OP_JAL])
        dec_o.imm = sext32({{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0});
      dec_o.rd_we    = !(cls[OP_BRANCH] || cls[OP_STORE]) && (instr_i[11:7] != 5'd0);
      dec_o.uses_rs1 = !(cls[OP_LUI] || cls[OP_AUIPC] || cls[OP_JAL]);
      dec_o.uses_rs2 = cls[OP_ALUREG] || cls[OP_BRANCH] || cls[OP_STORE];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: output register plus skid register so that
// in_ready never depends combinationally on out_ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int ALLOW_SYSTEM = 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  decode_stage_if.slave bus
);

  decode_bundle_t dec, out_q, out_d, skid_q, skid_d;
  logic           out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic           in_ready, in_fire;

  instr_decode_comb #(.XLEN(XLEN), .ALLOW_SYSTEM(ALLOW_SYSTEM)) u_comb (
    .instr_i (bus.in_instr),
    .pc_i    (bus.in_pc),
    .dec_o   (dec)
  );

  assign in_ready = resetn && !skid_vld_q;
  assign in_fire  = bus.in_valid && in_ready;

  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || bus.out_ready) begin
      // Output slot frees up: a parked skid entry always goes first.
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_fire) begin
        out_d     = dec;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_vld_q;
  assign bus.out_pc       = out_q.pc[XLEN-1:0];
  assign bus.out_op       = out_q.op;
  assign bus.out_rs1      = out_q.rs1;
  assign bus.out_rs2      = out_q.rs2;
  assign bus.out_rd       = out_q.rd;
  assign bus.out_funct3   = out_q.funct3;
  assign bus.out_funct7   = out_q.funct7;
  assign bus.out_imm      = out_q.imm[XLEN-1:0];
  assign bus.out_rd_we    = out_q.rd_we;
  assign bus.out_uses_rs1 = out_q.uses_rs1;
  assign bus.out_uses_rs2 = out_q.uses_rs2;
  assign bus.out_illegal  = out_q.illegal;
  assign bus.out_muldiv   = out_q.muldiv;

  generate
    if (XLEN < XLEN_MAX) begin : g_trunc
      logic unused_hi;
      assign unused_hi = ^{out_q.pc[XLEN_MAX-1:XLEN], out_q.imm[XLEN_MAX-1:XLEN]};
    end
  endgenerate

endmodule
